// File: rtl/fpu_operand_stage.sv
// FP operand fetch stage: 64x32 register file plus a single-entry output register toward the FPU.
// Optional macro FPU_OPSTAGE_BYPASS_EN enables writeback bypass on capture and refresh of held operands.
module fpu_operand_stage (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_ctrl,
    input  logic [5:0]  in_ds,
    input  logic [5:0]  in_dt,
    input  logic [5:0]  in_dd,
    input  logic [15:0] in_imm,
    input  logic [5:0]  wb_addr,
    input  logic [31:0] wb_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  ctrl,
    output logic [31:0] ds_val,
    output logic [31:0] dt_val,
    output logic [5:0]  dd,
    output logic [15:0] imm
);

`ifdef FPU_OPSTAGE_BYPASS_EN
    localparam bit BYPASS_EN = 1'b1;
`else
    localparam bit BYPASS_EN = 1'b0;
`endif

    logic [31:0] rf [64];
    logic [5:0]  ds_idx;
    logic [5:0]  dt_idx;
    logic        wb_hit;
    logic        accept;
    logic [31:0] ds_cap;
    logic [31:0] dt_cap;
    logic        ds_refresh;
    logic        dt_refresh;

    // Handshake: a transfer happens on an edge where valid && ready; the output side
    // holds everything stable while out_valid && !out_ready (only operand refresh may change).
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign wb_hit   = (wb_addr != 6'd0);

    always_comb begin
        ds_cap = '0;
        dt_cap = '0;
        if (in_ds != 6'd0)
            ds_cap = (BYPASS_EN && wb_hit && in_ds == wb_addr) ? wb_val : rf[in_ds];
        if (in_dt != 6'd0)
            dt_cap = (BYPASS_EN && wb_hit && in_dt == wb_addr) ? wb_val : rf[in_dt];
    end

    // A held index is never 0 when it matches a nonzero wb_addr, so register 0 stays zero.
    assign ds_refresh = BYPASS_EN && wb_hit && (ds_idx == wb_addr);
    assign dt_refresh = BYPASS_EN && wb_hit && (dt_idx == wb_addr);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) rf[i] <= '0;
        end else if (wb_hit) begin
            rf[wb_addr] <= wb_val;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            ctrl      <= '0;
            ds_val    <= '0;
            dt_val    <= '0;
            dd        <= '0;
            imm       <= '0;
            ds_idx    <= '0;
            dt_idx    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            ctrl      <= in_ctrl;
            ds_val    <= ds_cap;
            dt_val    <= dt_cap;
            dd        <= in_dd;
            imm       <= in_imm;
            ds_idx    <= in_ds;
            dt_idx    <= in_dt;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end else if (out_valid) begin
            if (ds_refresh) ds_val <= wb_val;
            if (dt_refresh) dt_val <= wb_val;
        end
    end

endmodule

// File: tb/tb_fpu_operand_stage.sv
// Bench for fpu_operand_stage: directed scenarios with literal expectations plus a random
// phase compared every cycle against a behavioural model of the stage.
module tb_fpu_operand_stage;

`ifdef FPU_OPSTAGE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk;
    logic        rstn;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_ctrl;
    logic [5:0]  in_ds;
    logic [5:0]  in_dt;
    logic [5:0]  in_dd;
    logic [15:0] in_imm;
    logic [5:0]  wb_addr;
    logic [31:0] wb_val;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  ctrl;
    logic [31:0] ds_val;
    logic [31:0] dt_val;
    logic [5:0]  dd;
    logic [15:0] imm;

    int n_cmp = 0;
    int n_bad = 0;

    fpu_operand_stage dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_ds(in_ds), .in_dt(in_dt), .in_dd(in_dd), .in_imm(in_imm),
        .wb_addr(wb_addr), .wb_val(wb_val), .out_valid(out_valid), .out_ready(out_ready),
        .ctrl(ctrl), .ds_val(ds_val), .dt_val(dt_val), .dd(dd), .imm(imm)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // behavioural model: register array plus the one instruction the stage is holding
    logic [31:0] m_rf [64];
    logic        m_valid;
    logic [3:0]  m_ctrl;
    logic [5:0]  m_dd, m_ds_idx, m_dt_idx;
    logic [15:0] m_imm;
    logic [31:0] m_ds, m_dt;

    function automatic logic [31:0] m_read(input logic [5:0] idx);
        if (idx == 6'd0) return 32'h0;
        if (BYP && wb_addr == idx) return wb_val;
        return m_rf[idx];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) m_rf[i] = 32'h0;
            m_valid = 0; m_ctrl = 0; m_dd = 0; m_imm = 0;
            m_ds_idx = 0; m_dt_idx = 0; m_ds = 0; m_dt = 0;
        end else begin
            if (in_valid && (!m_valid || out_ready)) begin
                m_valid = 1; m_ctrl = in_ctrl; m_dd = in_dd; m_imm = in_imm;
                m_ds_idx = in_ds; m_dt_idx = in_dt;
                m_ds = m_read(in_ds); m_dt = m_read(in_dt);
            end else if (m_valid && out_ready) begin
                m_valid = 0;
            end else if (m_valid && BYP && wb_addr != 6'd0) begin
                if (m_ds_idx == wb_addr) m_ds = wb_val;
                if (m_dt_idx == wb_addr) m_dt = wb_val;
            end
            if (wb_addr != 6'd0) m_rf[wb_addr] = wb_val;
        end
    end

    // scoreboard compare, mid-cycle
    always @(negedge clk) begin
        if (rstn) begin
            chk("in_ready", {31'h0, in_ready}, {31'h0, !m_valid || out_ready});
            chk("out_valid", {31'h0, out_valid}, {31'h0, m_valid});
            chk("ctrl", {28'h0, ctrl}, {28'h0, m_ctrl});
            chk("dd", {26'h0, dd}, {26'h0, m_dd});
            chk("imm", {16'h0, imm}, {16'h0, m_imm});
            chk("ds_val", ds_val, m_ds);
            chk("dt_val", dt_val, m_dt);
        end
    end

    // driver tasks
    task automatic drive(input logic v, input logic [3:0] c, input logic [5:0] s, input logic [5:0] t,
                         input logic [5:0] d, input logic [15:0] im, input logic [5:0] wa,
                         input logic [31:0] wv, input logic ordy);
        in_valid = v; in_ctrl = c; in_ds = s; in_dt = t; in_dd = d; in_imm = im;
        wb_addr = wa; wb_val = wv; out_ready = ordy;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rstn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) tick();
        chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
        chk("rst_ds_val", ds_val, 32'h0);
        chk("rst_ctrl", {28'h0, ctrl}, 32'h0);
        rstn = 1'b1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);

        // basic write then read
        drive(0, 4'h3, 0, 0, 0, 0, 6'd5, 32'h3F800000, 1); tick();
        drive(1, 4'h3, 6'd5, 6'd0, 6'd9, 16'hBEEF, 0, 0, 1); tick();
        chk("basic_valid", {31'h0, out_valid}, 32'h1);
        chk("basic_ds", ds_val, 32'h3F800000);
        chk("basic_dt", dt_val, 32'h0);
        chk("basic_imm", {16'h0, imm}, 32'h0000BEEF);

        // same-cycle bypass on both sources
        drive(0, 0, 0, 0, 0, 0, 6'd7, 32'h11111111, 1); tick();
        drive(1, 4'h1, 6'd7, 6'd7, 6'd2, 0, 6'd7, 32'h40000000, 1); tick();
        chk("bypass_ds", ds_val, BYP ? 32'h40000000 : 32'h11111111);
        chk("bypass_dt", dt_val, BYP ? 32'h40000000 : 32'h11111111);

        // stall with refresh of a held operand
        drive(0, 0, 0, 0, 0, 0, 6'd3, 32'h12345678, 1); tick();
        drive(1, 4'h5, 6'd3, 6'd4, 6'd11, 16'h0042, 0, 0, 0); tick();
        chk("stall_ds0", ds_val, 32'h12345678);
        chk("stall_ready0", {31'h0, in_ready}, 32'h0);
        drive(1, 4'h6, 6'd8, 6'd8, 6'd12, 16'h0099, 6'd3, 32'hC0000000, 0); tick();
        chk("stall_ds1", ds_val, BYP ? 32'hC0000000 : 32'h12345678);
        chk("stall_ready1", {31'h0, in_ready}, 32'h0);
        chk("stall_dd", {26'h0, dd}, 32'd11);
        chk("stall_ctrl", {28'h0, ctrl}, 32'h5);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        chk("drain_valid", {31'h0, out_valid}, 32'h0);

        // register 0 never written
        drive(0, 0, 0, 0, 0, 0, 6'd0, 32'hFFFFFFFF, 1); tick();
        drive(1, 0, 6'd0, 6'd0, 6'd1, 0, 6'd0, 32'hFFFFFFFF, 1); tick();
        chk("r0_ds", ds_val, 32'h0);
        chk("r0_dt", dt_val, 32'h0);

        // back-to-back streaming, ctrl extremes pass through
        for (int k = 1; k <= 4; k++) begin
            drive(1, (k == 1) ? 4'h0 : 4'hF, 6'd5, 6'd3, 6'(k), 16'(k), 0, 0, 1);
            tick();
            chk("stream_dd", {26'h0, dd}, 32'(k));
            chk("stream_valid", {31'h0, out_valid}, 32'h1);
            chk("stream_ctrl", {28'h0, ctrl}, (k == 1) ? 32'h0 : 32'hF);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();

        // random phase against the model
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 6'($urandom_range(0, 7)),
                  6'($urandom_range(0, 7)), 6'($urandom_range(0, 63)), 16'($urandom),
                  6'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) != 0);
            tick();
        end

        // reset asserted in the middle of a stall
        drive(0, 0, 0, 0, 0, 0, 6'd5, 32'hAAAA5555, 1); tick();
        drive(1, 4'h2, 6'd5, 6'd5, 6'd6, 0, 0, 0, 0); tick();
        chk("prerst_valid", {31'h0, out_valid}, 32'h1);
        chk("prerst_ds", ds_val, 32'hAAAA5555);
        #1 rstn = 1'b0;
        #1;
        chk("async_valid", {31'h0, out_valid}, 32'h0);
        chk("async_ds", ds_val, 32'h0);
        drive(1, 4'h2, 6'd5, 6'd5, 6'd6, 0, 6'd5, 32'h77777777, 1);
        repeat (2) tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b1;
        chk("postrst_ready", {31'h0, in_ready}, 32'h1);
        tick();
        drive(1, 0, 6'd5, 6'd0, 6'd1, 0, 0, 0, 1); tick();
        chk("postrst_rf5", ds_val, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fpu_operand_stage.md
FPU_OPERAND_STAGE -- requirements
Module: fpu_operand_stage

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rstn input 1, asynchronous active-low reset.
REQ-002 SHALL have port in_valid input 1: upstream presents an FP instruction.
REQ-003 SHALL have port in_ready output 1: stage accepts an instruction this cycle.
REQ-004 SHALL have ports in_ctrl input 4, in_ds input 6, in_dt input 6, in_dd input 6, in_imm input 16: decoded op code, source indices, destination index, immediate.
REQ-005 SHALL have port wb_addr input 6: writeback index from the FPU reg_addr; 0 means no write.
REQ-006 SHALL have port wb_val input 32: writeback data from the FPU dd_val.
REQ-007 SHALL have port out_valid output 1: held instruction is valid toward the FPU.
REQ-008 SHALL have port out_ready input 1: FPU side consumes the held instruction.
REQ-009 SHALL have ports ctrl output 4, ds_val output 32, dt_val output 32, dd output 6, imm output 16: registered operands toward the FPU.

Function
REQ-010 SHALL contain a 64 x 32 FP register file; entry 0 SHALL read as 32'h0 and SHALL never be written.
REQ-011 SHALL write wb_val into entry wb_addr on each rising clk when wb_addr != 0, regardless of handshake state.
REQ-012 SHALL drive in_ready = !out_valid || out_ready (combinational, single-entry skid-free buffer).
REQ-013 SHALL accept on a clock edge with in_valid && in_ready: latch in_ctrl, in_dd, in_imm, in_ds and in_dt indices, ds_val = RF[in_ds], dt_val = RF[in_dt]; set out_valid = 1 next cycle (latency 1).
REQ-014 SHALL clear out_valid on an edge with out_valid && out_ready && !in_valid; when in_valid is also high, SHALL load the new instruction and keep out_valid = 1 (back-to-back, no bubble).
REQ-015 SHALL hold all outputs stable while out_valid && !out_ready, except as stated in REQ-017.
REQ-016 SHALL, when capturing, select wb_val instead of the array value for any source whose index equals a nonzero wb_addr in the same cycle (bypass); ds == dt == wb_addr SHALL bypass both.
REQ-017 SHALL, while holding (out_valid && !out_ready), replace ds_val and/or dt_val with wb_val on each edge where the stored index equals a nonzero wb_addr.
REQ-018 SHALL force ds_val/dt_val to 0 for any source index 0, including during bypass and refresh.
REQ-019 SHALL leave ctrl, dd, imm and the stored indices unchanged by writebacks.
REQ-020 SHALL pass ctrl values 0 and 15 through unchanged; the stage does not decode ctrl.

Reset
REQ-021 SHALL, on rstn low, immediately clear out_valid, ctrl, ds_val, dt_val, dd, imm, stored indices and all 64 register entries to 0, independent of clk.
REQ-022 SHALL discard any held instruction when reset is asserted mid-stall; in_ready SHALL be 1 in the first cycle after rstn deasserts.
REQ-023 SHALL ignore in_valid and wb_addr while rstn is low.

Configuration
REQ-024 SHALL honour macro FPU_OPSTAGE_BYPASS_EN: when defined, REQ-016 and REQ-017 apply.
REQ-025 SHALL, without FPU_OPSTAGE_BYPASS_EN, capture pre-write array contents and never refresh held operands; upstream then guarantees a one-cycle gap between a write and a dependent read; all other behaviour is unchanged.

Verification
REQ-026 SHALL cover basic write/read: wb_addr=5, wb_val=32'h3F800000; next cycle in_ds=5, in_dt=0, in_valid=1 -> one cycle later out_valid=1, ds_val=32'h3F800000, dt_val=0.
REQ-027 SHALL cover same-cycle bypass (macro on): wb_addr=7, wb_val=32'h40000000, and in_ds=in_dt=7 in the same cycle -> ds_val=dt_val=32'h40000000; with the macro off -> the old RF[7] value.
REQ-028 SHALL cover stall refresh: hold with out_ready=0 and held ds index 3, then write wb_addr=3, wb_val=32'hC0000000 -> ds_val becomes 32'hC0000000 next cycle; in_ready stays 0 throughout.
REQ-029 SHALL cover register 0: wb_addr=0, wb_val=32'hFFFFFFFF, then read in_ds=0 -> ds_val=0.
REQ-030 SHALL cover streaming: in_valid=1 and out_ready=1 for 4 cycles with distinct in_dd 1..4 -> dd sequence 1,2,3,4 on consecutive cycles with out_valid continuously 1.
REQ-031 SHALL cover reset during a stall: rstn pulsed low mid-cycle while out_valid=1 -> out_valid=0 and ds_val=0 asynchronously; RF[5]=0 afterwards.
